// File: rtl/axil_pkg.sv
// Shared AXI4-Lite write-side constants and helpers.
// Optional range checking in the top level is enabled by defining AXIL_WR_RANGE_CHECK_EN.
package axil_pkg;

    localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

    function automatic int axil_strb_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/axil_wr_regfile.sv
// Word-addressed register file with a byte-strobed write port and a combinational read port.
// All words clear on asynchronous active-low reset.
module axil_wr_regfile
    import axil_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    localparam int STRB_W = axil_strb_w(DATA_W),
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_widx,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [STRB_W-1:0] i_wstrb,
    input  logic [IDX_W-1:0]  i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_widx][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/axil_write_responder.sv
// AXI4-Lite write endpoint: holds AW and W independently, commits into a register file, returns B.
// Define AXIL_WR_RANGE_CHECK_EN to reject word addresses beyond DEPTH with SLVERR.
module axil_write_responder
    import axil_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    localparam int STRB_W = axil_strb_w(DATA_W),
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] s_axil_awaddr,
    input  logic [2:0]        s_axil_awprot,
    input  logic              s_axil_awvalid,
    output logic              s_axil_awready,
    input  logic [DATA_W-1:0] s_axil_wdata,
    input  logic [STRB_W-1:0] s_axil_wstrb,
    input  logic              s_axil_wvalid,
    output logic              s_axil_wready,
    output logic [1:0]        s_axil_bresp,
    output logic              s_axil_bvalid,
    input  logic              s_axil_bready,
    output logic              wr_notify,
    output logic [IDX_W-1:0]  wr_notify_idx,
    input  logic [IDX_W-1:0]  debug_addr,
    output logic [DATA_W-1:0] debug_data
);

    // Handshakes: a beat transfers on the rising edge where valid && ready are both high;
    // ready depends only on local state, never on the partner's valid, and B holds until bready.
    logic              r_aw_full;
    logic [IDX_W-1:0]  r_aw_idx;
    logic              r_aw_err;
    logic              r_w_full;
    logic [DATA_W-1:0] r_wdata;
    logic [STRB_W-1:0] r_wstrb;
    logic              r_bvalid;
    logic [1:0]        r_bresp;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;
    logic w_commit;
    logic w_commit_ok;
    logic w_aw_oor;
    logic w_unused_bits;

    assign w_aw_hs     = s_axil_awvalid && !r_aw_full;
    assign w_w_hs      = s_axil_wvalid && !r_w_full;
    assign w_b_hs      = r_bvalid && s_axil_bready;
    assign w_commit    = r_aw_full && r_w_full && !r_bvalid;
    assign w_commit_ok = w_commit && !r_aw_err;

`ifdef AXIL_WR_RANGE_CHECK_EN
    assign w_aw_oor      = |s_axil_awaddr[ADDR_W-1:2+IDX_W];
    assign w_unused_bits = ^{s_axil_awprot, s_axil_awaddr[1:0]};
`else
    assign w_aw_oor      = 1'b0;
    assign w_unused_bits = ^{s_axil_awprot, s_axil_awaddr[1:0], s_axil_awaddr[ADDR_W-1:2+IDX_W]};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_aw_full <= 1'b0;
            r_aw_idx  <= '0;
            r_aw_err  <= 1'b0;
        end else if (w_commit) begin
            r_aw_full <= 1'b0;
        end else if (w_aw_hs) begin
            r_aw_full <= 1'b1;
            r_aw_idx  <= s_axil_awaddr[2 +: IDX_W];
            r_aw_err  <= w_aw_oor;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_w_full <= 1'b0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
        end else if (w_commit) begin
            r_w_full <= 1'b0;
        end else if (w_w_hs) begin
            r_w_full <= 1'b1;
            r_wdata  <= s_axil_wdata;
            r_wstrb  <= s_axil_wstrb;
        end
    end

    // A commit can only start with B idle, so setting and clearing bvalid never collide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bvalid <= 1'b0;
            r_bresp  <= AXIL_RESP_OKAY;
        end else if (w_commit) begin
            r_bvalid <= 1'b1;
            r_bresp  <= r_aw_err ? AXIL_RESP_SLVERR : AXIL_RESP_OKAY;
        end else if (w_b_hs) begin
            r_bvalid <= 1'b0;
        end
    end

    axil_wr_regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_commit_ok),
        .i_widx  (r_aw_idx),
        .i_wdata (r_wdata),
        .i_wstrb (r_wstrb),
        .i_raddr (debug_addr),
        .o_rdata (debug_data)
    );

    assign s_axil_awready = !r_aw_full;
    assign s_axil_wready  = !r_w_full;
    assign s_axil_bvalid  = r_bvalid;
    assign s_axil_bresp   = r_bresp;
    assign wr_notify      = w_commit_ok;
    assign wr_notify_idx  = r_aw_idx;

endmodule

// File: tb/tb_axil_write_responder.sv
// Bench for axil_write_responder: vector table, directed corner sequences, randomized traffic vs a model.
// Expectations follow AXIL_WR_RANGE_CHECK_EN when it is defined.
module tb_axil_write_responder;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int IDX_W  = 4;
    localparam int STRB_W = 4;
    localparam int N_RAND = 40;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] s_axil_awaddr;
    logic [2:0]        s_axil_awprot;
    logic              s_axil_awvalid;
    logic              s_axil_awready;
    logic [DATA_W-1:0] s_axil_wdata;
    logic [STRB_W-1:0] s_axil_wstrb;
    logic              s_axil_wvalid;
    logic              s_axil_wready;
    logic [1:0]        s_axil_bresp;
    logic              s_axil_bvalid;
    logic              s_axil_bready;
    logic              wr_notify;
    logic [IDX_W-1:0]  wr_notify_idx;
    logic [IDX_W-1:0]  debug_addr;
    logic [DATA_W-1:0] debug_data;

    always #5 clk = ~clk;

    axil_write_responder #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s_axil_awaddr  (s_axil_awaddr),
        .s_axil_awprot  (s_axil_awprot),
        .s_axil_awvalid (s_axil_awvalid),
        .s_axil_awready (s_axil_awready),
        .s_axil_wdata   (s_axil_wdata),
        .s_axil_wstrb   (s_axil_wstrb),
        .s_axil_wvalid  (s_axil_wvalid),
        .s_axil_wready  (s_axil_wready),
        .s_axil_bresp   (s_axil_bresp),
        .s_axil_bvalid  (s_axil_bvalid),
        .s_axil_bready  (s_axil_bready),
        .wr_notify      (wr_notify),
        .wr_notify_idx  (wr_notify_idx),
        .debug_addr     (debug_addr),
        .debug_data     (debug_data)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0]      exp_mem [DEPTH];
    logic [15:0]      pend_aw [$];
    logic [35:0]      pend_w  [$];
    logic [1:0]       exp_b_q [$];
    logic [IDX_W-1:0] exp_n_q [$];
    bit               mon_en = 1'b0;

    function automatic void model_pair();
        while (pend_aw.size() > 0 && pend_w.size() > 0) begin
            logic [15:0] a;
            logic [35:0] w;
            int          word;
            int          idx;
            bit          oor;
            a    = pend_aw.pop_front();
            w    = pend_w.pop_front();
            word = int'(a) / 4;
            idx  = word % DEPTH;
`ifdef AXIL_WR_RANGE_CHECK_EN
            oor = (word >= DEPTH);
`else
            oor = 1'b0;
`endif
            if (oor) begin
                exp_b_q.push_back(2'b10);
            end else begin
                exp_b_q.push_back(2'b00);
                exp_n_q.push_back(IDX_W'(idx));
                for (int b = 0; b < 4; b++) begin
                    if (w[32+b]) exp_mem[idx][8*b +: 8] = w[8*b +: 8];
                end
            end
        end
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (wr_notify) begin
                if (exp_n_q.size() == 0) check("rand_unexpected_notify", 32'd1, 32'd0);
                else check("rand_notify_idx", 32'(wr_notify_idx), 32'(exp_n_q.pop_front()));
            end
            if (s_axil_bvalid && s_axil_bready) begin
                if (exp_b_q.size() == 0) check("rand_unexpected_b", 32'd1, 32'd0);
                else check("rand_bresp", 32'(s_axil_bresp), 32'(exp_b_q.pop_front()));
            end
            if (s_axil_awvalid && s_axil_awready) pend_aw.push_back(s_axil_awaddr);
            if (s_axil_wvalid && s_axil_wready) pend_w.push_back({s_axil_wstrb, s_axil_wdata});
            model_pair();
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0]      addr;
        logic [31:0]      data;
        logic [3:0]       strb;
        logic             exp_notify;
        logic [IDX_W-1:0] exp_idx;
        logic [1:0]       exp_resp;
        logic [31:0]      exp_word;
    } vec_t;

    vec_t vecs [6];

    task automatic apply_vec(input vec_t v, input string tag);
        @(posedge clk); #1;
        s_axil_awaddr  = v.addr;
        s_axil_awvalid = 1'b1;
        s_axil_wdata   = v.data;
        s_axil_wstrb   = v.strb;
        s_axil_wvalid  = 1'b1;
        s_axil_bready  = 1'b1;
        @(negedge clk);
        check({tag, "_awready"}, 32'(s_axil_awready), 32'd1);
        check({tag, "_wready"}, 32'(s_axil_wready), 32'd1);
        @(posedge clk); #1;
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        @(negedge clk);
        check({tag, "_notify"}, 32'(wr_notify), 32'(v.exp_notify));
        if (v.exp_notify) check({tag, "_notify_idx"}, 32'(wr_notify_idx), 32'(v.exp_idx));
        check({tag, "_bvalid_early"}, 32'(s_axil_bvalid), 32'd0);
        @(negedge clk);
        check({tag, "_bvalid"}, 32'(s_axil_bvalid), 32'd1);
        check({tag, "_bresp"}, 32'(s_axil_bresp), 32'(v.exp_resp));
        @(posedge clk); #1;
        debug_addr = v.exp_idx;
        #1;
        check({tag, "_mem"}, debug_data, v.exp_word);
        @(negedge clk);
        check({tag, "_bvalid_clear"}, 32'(s_axil_bvalid), 32'd0);
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        s_axil_bready  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic read_mem(input int idx, input logic [31:0] exp, input string name);
        debug_addr = IDX_W'(idx);
        #1;
        check(name, debug_data, exp);
    endtask

    // ---------------- randomized drivers ----------------
    bit aw_done, w_done;

    task automatic rand_aw(input int n);
        int t;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            s_axil_awaddr  = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 63))
                                                         : 16'($urandom_range(0, 16'hFFFF));
            s_axil_awprot  = 3'($urandom_range(0, 7));
            s_axil_awvalid = 1'b1;
            t = 0;
            @(negedge clk);
            while (!s_axil_awready && t < 200) begin @(negedge clk); t++; end
            check("rand_aw_accept", 32'(s_axil_awready), 32'd1);
            @(posedge clk); #1;
            s_axil_awvalid = 1'b0;
        end
        aw_done = 1'b1;
    endtask

    task automatic rand_w(input int n);
        int t;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            s_axil_wdata  = $urandom;
            s_axil_wstrb  = 4'($urandom_range(0, 15));
            s_axil_wvalid = 1'b1;
            t = 0;
            @(negedge clk);
            while (!s_axil_wready && t < 200) begin @(negedge clk); t++; end
            check("rand_w_accept", 32'(s_axil_wready), 32'd1);
            @(posedge clk); #1;
            s_axil_wvalid = 1'b0;
        end
        w_done = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        s_axil_awaddr = '0;
        s_axil_awprot = '0;
        s_axil_wdata  = '0;
        s_axil_wstrb  = '0;
        debug_addr    = '0;

        // Reset with valids asserted: nothing may be captured.
        rst            = 1'b0;
        s_axil_awvalid = 1'b1;
        s_axil_wvalid  = 1'b1;
        s_axil_bready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awready", 32'(s_axil_awready), 32'd1);
        check("rst_wready", 32'(s_axil_wready), 32'd1);
        check("rst_bvalid", 32'(s_axil_bvalid), 32'd0);
        check("rst_bresp", 32'(s_axil_bresp), 32'd0);
        check("rst_notify", 32'(wr_notify), 32'd0);
        for (int i = 0; i < DEPTH; i++) read_mem(i, 32'h0, "rst_mem");
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        @(posedge clk); #1 rst = 1'b1;

        // Same-cycle AW+W table, applied in order on a freshly reset register file.
        vecs[0] = '{16'h0008, 32'hDEADBEEF, 4'hF, 1'b1, 4'd2,  2'b00, 32'hDEADBEEF};
        vecs[1] = '{16'h000A, 32'h11223344, 4'h3, 1'b1, 4'd2,  2'b00, 32'hDEAD3344};
        vecs[2] = '{16'h0004, 32'hCAFEF00D, 4'h0, 1'b1, 4'd1,  2'b00, 32'h00000000};
        vecs[3] = '{16'h003C, 32'h12345678, 4'hC, 1'b1, 4'd15, 2'b00, 32'h12340000};
`ifdef AXIL_WR_RANGE_CHECK_EN
        vecs[4] = '{16'h0040, 32'hA5A5A5A5, 4'hF, 1'b0, 4'd0,  2'b10, 32'h00000000};
        vecs[5] = '{16'hFFFC, 32'h000000EE, 4'h1, 1'b0, 4'd15, 2'b10, 32'h12340000};
`else
        vecs[4] = '{16'h0040, 32'hA5A5A5A5, 4'hF, 1'b1, 4'd0,  2'b00, 32'hA5A5A5A5};
        vecs[5] = '{16'hFFFC, 32'h000000EE, 4'h1, 1'b1, 4'd15, 2'b00, 32'h123400EE};
`endif
        for (int i = 0; i < 6; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

        // W first, AW three cycles later: no commit before AW, upper bytes kept.
        apply_vec('{16'h000C, 32'h55667788, 4'hF, 1'b1, 4'd3, 2'b00, 32'h55667788}, "wf_pre");
        @(posedge clk); #1;
        s_axil_wdata  = 32'h000000AA;
        s_axil_wstrb  = 4'h1;
        s_axil_wvalid = 1'b1;
        @(posedge clk); #1;
        s_axil_wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("wf_wready_held", 32'(s_axil_wready), 32'd0);
            check("wf_no_notify", 32'(wr_notify), 32'd0);
            check("wf_no_bvalid", 32'(s_axil_bvalid), 32'd0);
        end
        @(posedge clk); #1;
        s_axil_awaddr  = 16'h000C;
        s_axil_awvalid = 1'b1;
        @(posedge clk); #1;
        s_axil_awvalid = 1'b0;
        @(negedge clk);
        check("wf_notify", 32'(wr_notify), 32'd1);
        check("wf_notify_idx", 32'(wr_notify_idx), 32'd3);
        @(negedge clk);
        check("wf_bvalid", 32'(s_axil_bvalid), 32'd1);
        check("wf_bresp", 32'(s_axil_bresp), 32'd0);
        @(posedge clk); #1;
        read_mem(3, 32'h556677AA, "wf_mem");

        // B backpressure with a second transaction queued behind it.
        s_axil_bready  = 1'b0;
        s_axil_awaddr  = 16'h0010;
        s_axil_wdata   = 32'h00000001;
        s_axil_wstrb   = 4'hF;
        s_axil_awvalid = 1'b1;
        s_axil_wvalid  = 1'b1;
        @(posedge clk); #1;
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        @(negedge clk);
        check("bp_notify1", 32'(wr_notify_idx), 32'd4);
        @(posedge clk); #1;
        s_axil_awaddr  = 16'h0014;
        s_axil_wdata   = 32'h00000002;
        s_axil_awvalid = 1'b1;
        s_axil_wvalid  = 1'b1;
        @(negedge clk);
        check("bp_aw2_ready", 32'(s_axil_awready), 32'd1);
        @(posedge clk); #1;
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_bvalid_hold", 32'(s_axil_bvalid), 32'd1);
            check("bp_bresp_hold", 32'(s_axil_bresp), 32'd0);
            check("bp_awready_drop", 32'(s_axil_awready), 32'd0);
            check("bp_wready_drop", 32'(s_axil_wready), 32'd0);
            check("bp_no_notify", 32'(wr_notify), 32'd0);
        end
        @(posedge clk); #1;
        s_axil_bready = 1'b1;
        @(negedge clk);
        check("bp_no_notify_pre_hs", 32'(wr_notify), 32'd0);
        @(negedge clk);
        check("bp_bvalid_gap", 32'(s_axil_bvalid), 32'd0);
        check("bp_notify2", 32'(wr_notify), 32'd1);
        check("bp_notify2_idx", 32'(wr_notify_idx), 32'd5);
        @(negedge clk);
        check("bp_bvalid2", 32'(s_axil_bvalid), 32'd1);
        @(posedge clk); #1;
        read_mem(4, 32'h00000001, "bp_mem4");
        read_mem(5, 32'h00000002, "bp_mem5");

        // Reset while AW is held and W not yet sent: the held AW must be dropped.
        @(posedge clk); #1;
        s_axil_awaddr  = 16'h0018;
        s_axil_awvalid = 1'b1;
        @(posedge clk); #1;
        s_axil_awvalid = 1'b0;
        #2 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        s_axil_wdata  = 32'h00000077;
        s_axil_wstrb  = 4'hF;
        s_axil_wvalid = 1'b1;
        @(posedge clk); #1;
        s_axil_wvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rm_no_notify", 32'(wr_notify), 32'd0);
            check("rm_no_bvalid", 32'(s_axil_bvalid), 32'd0);
            check("rm_awready", 32'(s_axil_awready), 32'd1);
        end
        @(posedge clk); #1;
        s_axil_awaddr  = 16'h001C;
        s_axil_awvalid = 1'b1;
        @(posedge clk); #1;
        s_axil_awvalid = 1'b0;
        @(negedge clk);
        check("rm_notify_idx", 32'(wr_notify_idx), 32'd7);
        @(negedge clk);
        @(posedge clk); #1;
        read_mem(6, 32'h0, "rm_mem6");
        read_mem(7, 32'h00000077, "rm_mem7");
        read_mem(4, 32'h0, "rm_mem4_cleared");

        // Randomized traffic checked against the model.
        do_reset();
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = 32'h0;
        pend_aw.delete();
        pend_w.delete();
        exp_b_q.delete();
        exp_n_q.delete();
        aw_done = 1'b0;
        w_done  = 1'b0;
        mon_en  = 1'b1;
        fork
            rand_aw(N_RAND);
            rand_w(N_RAND);
            begin
                while (!(aw_done && w_done)) begin
                    @(posedge clk); #1;
                    s_axil_bready = 1'($urandom_range(0, 1));
                end
            end
        join
        s_axil_bready = 1'b1;
        t = 0;
        while ((exp_b_q.size() != 0 || pend_aw.size() != 0) && t < 200) begin
            @(posedge clk);
            t++;
        end
        repeat (2) @(posedge clk);
        #1 mon_en = 1'b0;
        check("rand_b_drained", 32'(exp_b_q.size()), 32'd0);
        check("rand_notify_drained", 32'(exp_n_q.size()), 32'd0);
        for (int i = 0; i < DEPTH; i++) read_mem(i, exp_mem[i], $sformatf("rand_mem%0d", i));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
